// File: rtl/dmem_hs_if.sv
// Request/response bus for the MEM-stage data memory controller.
interface dmem_hs_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        misaligned;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, address, write_data,
    input  req_ready, resp_valid, read_data, misaligned
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, address, write_data,
    output req_ready, resp_valid, read_data, misaligned
  );
endinterface

// File: rtl/dmem_hs_ctrl.sv
// Byte-addressed data memory with a valid/ready handshake and programmable
// wait states. Byte/half/word accesses, sign/zero extended loads, and
// misaligned requests rejected without touching memory.
module dmem_hs_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1,
  parameter int INIT_INDEX  = 1
) (
  input logic      clk,
  input logic      rst,
  dmem_hs_if.slave bus
);
  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
  localparam int IW    = ADDR_WIDTH - 2;
  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  ready_q, resp_q, mis_q;
  logic [31:0]           rdata_q;
  logic                  wr_q, uns_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  // Address bits above the decoded range alias onto the array.
  logic unused_addr;
  assign unused_addr = ^bus.address[31:ADDR_WIDTH];

  logic accept, mis_in;
  assign accept = bus.req_valid && ready_q;
  // Half needs an even address; word (and size 11) needs a word boundary.
  assign mis_in = (bus.req_size == 2'b01 && bus.address[0]) ||
                  (bus.req_size[1] && bus.address[1:0] != 2'b00);

  // The access runs on live inputs at acceptance when there are no wait
  // states, otherwise on the latched request at the end of WAIT.
  logic                  acc_fire, acc_wr, acc_uns;
  logic [1:0]            acc_size;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [31:0]           acc_wdata;
  always_comb begin
    acc_fire  = 1'b0;
    acc_wr    = wr_q;
    acc_size  = size_q;
    acc_uns   = uns_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      acc_wr    = bus.req_write;
      acc_size  = bus.req_size;
      acc_uns   = bus.req_unsigned;
      acc_addr  = bus.address[ADDR_WIDTH-1:0];
      acc_wdata = bus.write_data;
      acc_fire  = accept && !mis_in && (WAIT_CYCLES == 0);
    end else if (state_q == S_WAIT) begin
      acc_fire  = (cnt_q == '0);
    end
  end

  logic [IW-1:0] acc_idx;
  logic [4:0]    acc_sh;
  logic [31:0]   words [DEPTH];
  logic [31:0]   rd_word, rd_shift, load_val, lane_mask, wr_word_d;
  logic          mem_we;

  assign acc_idx  = acc_addr[ADDR_WIDTH-1:2];
  assign acc_sh   = {acc_addr[1:0], 3'b000};
  assign rd_word  = words[acc_idx];
  assign rd_shift = rd_word >> acc_sh;

  // Right-align the selected lane and extend it.
  always_comb begin
    load_val = rd_word;
    case (acc_size)
      2'b00:   load_val = acc_uns ? {24'h0, rd_shift[7:0]}
                                  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = acc_uns ? {16'h0, rd_shift[15:0]}
                                  : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = rd_word;
    endcase
  end

  // Lanes touched by a store; untouched bytes keep their old value.
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    case (acc_size)
      2'b00:   lane_mask = 32'h0000_00FF << acc_sh;
      2'b01:   lane_mask = 32'h0000_FFFF << acc_sh;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign wr_word_d = (rd_word & ~lane_mask) | ((acc_wdata << acc_sh) & lane_mask);
  // Reset aborts a store even on the edge where it would have committed.
  assign mem_we    = acc_fire && acc_wr && !rst;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [31:0] word_q = (INIT_INDEX != 0) ? 32'(i) : 32'h0;
    // Storage word; contents survive reset.
    always_ff @(posedge clk)
      if (mem_we && acc_idx == IW'(i)) word_q <= wr_word_d;
    assign words[i] = word_q;
  end

  // Handshake FSM with registered ready/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          wr_q    <= bus.req_write;
          size_q  <= bus.req_size;
          uns_q   <= bus.req_unsigned;
          addr_q  <= bus.address[ADDR_WIDTH-1:0];
          wdata_q <= bus.write_data;
          ready_q <= 1'b0;
          if (mis_in) begin
            state_q <= S_RESP;
            resp_q  <= 1'b1;
            mis_q   <= 1'b1;
            rdata_q <= '0;
          end else if (WAIT_CYCLES == 0) begin
            state_q <= S_RESP;
            resp_q  <= 1'b1;
            mis_q   <= 1'b0;
            rdata_q <= bus.req_write ? 32'h0 : load_val;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= CNT_LOAD;
          end
        end
        S_WAIT: if (cnt_q == '0) begin
          state_q <= S_RESP;
          resp_q  <= 1'b1;
          mis_q   <= 1'b0;
          rdata_q <= wr_q ? 32'h0 : load_val;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_q;
  assign bus.read_data  = rdata_q;
  assign bus.misaligned = mis_q;
endmodule

// File: tb/tb_dmem_hs_ctrl.sv
// Directed bench: three instances (default, 3 wait states, 0 wait states).
`define CHK(tag, obs, exp) begin n_chk++; assert ((obs) === (exp)) else begin n_fail++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end end

module tb_dmem_hs_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dmem_hs_if bus0 ();
  dmem_hs_if bus1 ();
  dmem_hs_if bus2 ();

  dmem_hs_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(1), .INIT_INDEX(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_hs_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .INIT_INDEX(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dmem_hs_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .INIT_INDEX(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic drive(input int d, input bit v, input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [31:0] a, input logic [31:0] wd);
    case (d)
      0: begin bus0.req_valid = v; bus0.req_write = wr; bus0.req_size = sz;
               bus0.req_unsigned = uns; bus0.address = a; bus0.write_data = wd; end
      1: begin bus1.req_valid = v; bus1.req_write = wr; bus1.req_size = sz;
               bus1.req_unsigned = uns; bus1.address = a; bus1.write_data = wd; end
      default: begin bus2.req_valid = v; bus2.req_write = wr; bus2.req_size = sz;
               bus2.req_unsigned = uns; bus2.address = a; bus2.write_data = wd; end
    endcase
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? bus0.req_ready : (d == 1) ? bus1.req_ready : bus2.req_ready;
  endfunction
  function automatic logic rv(input int d);
    return (d == 0) ? bus0.resp_valid : (d == 1) ? bus1.resp_valid : bus2.resp_valid;
  endfunction
  function automatic logic [31:0] rdat(input int d);
    return (d == 0) ? bus0.read_data : (d == 1) ? bus1.read_data : bus2.read_data;
  endfunction
  function automatic logic rmis(input int d);
    return (d == 0) ? bus0.misaligned : (d == 1) ? bus1.misaligned : bus2.misaligned;
  endfunction

  // Results of the last transaction: latency in cycles after the accepting
  // edge (-1 on timeout), response data, and whether ready stayed low.
  int          lat;
  logic [31:0] rd;
  logic        mis;
  logic        busy_lo;

  task automatic xact(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(negedge clk);
    drive(d, 1'b1, wr, sz, uns, a, wd);
    n = 0;
    while (!rdy(d) && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 drive(d, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    lat = -1; rd = 'x; mis = 1'bx; busy_lo = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rdy(d)) busy_lo = 1'b0;
      if (rv(d)) begin lat = k; rd = rdat(d); mis = rmis(d); break; end
    end
  endtask

  int got, bad;

  initial begin
    drive(0, 0, 0, 2'b10, 0, 0, 0);
    drive(1, 0, 0, 2'b10, 0, 0, 0);
    drive(2, 0, 0, 2'b10, 0, 0, 0);

    // Reset state
    @(negedge clk);
    `CHK("rst_ready", rdy(0), 1'b1)
    `CHK("rst_resp_valid", rv(0), 1'b0)
    `CHK("rst_read_data", rdat(0), 32'h0)
    `CHK("rst_misaligned", rmis(0), 1'b0)
    rst = 1'b0;

    // Default load, latency WAIT_CYCLES+1, ready low while busy
    xact(0, 0, 2'b10, 0, 32'h14, 0);
    `CHK("ld14_data", rd, 32'h0000_0005)
    `CHK("ld14_lat", lat, 2)
    `CHK("ld14_mis", mis, 1'b0)
    `CHK("ld14_busy", busy_lo, 1'b1)

    // Byte store merge
    xact(0, 1, 2'b00, 0, 32'h11, 32'hFFFF_FFAB);
    `CHK("stb11_data", rd, 32'h0)
    `CHK("stb11_lat", lat, 2)
    xact(0, 0, 2'b10, 0, 32'h10, 0);
    `CHK("ld10_word", rd, 32'h0000_AB04)
    xact(0, 0, 2'b00, 0, 32'h11, 0);
    `CHK("ldb11_signed", rd, 32'hFFFF_FFAB)
    xact(0, 0, 2'b00, 1, 32'h11, 0);
    `CHK("ldb11_unsigned", rd, 32'h0000_00AB)

    // Half store merge and extension
    xact(0, 1, 2'b01, 0, 32'h22, 32'h1234_8001);
    `CHK("sth22_data", rd, 32'h0)
    xact(0, 0, 2'b10, 0, 32'h20, 0);
    `CHK("ld20_word", rd, 32'h8001_0008)
    xact(0, 0, 2'b01, 0, 32'h22, 0);
    `CHK("ldh22_signed", rd, 32'hFFFF_8001)
    xact(0, 0, 2'b01, 1, 32'h22, 0);
    `CHK("ldh22_unsigned", rd, 32'h0000_8001)
    xact(0, 0, 2'b00, 0, 32'h23, 0);
    `CHK("ldb23_signed", rd, 32'hFFFF_FF80)
    xact(0, 0, 2'b11, 1, 32'h0C, 0);
    `CHK("ld0c_size11", rd, 32'h0000_0003)

    // Misalignment
    xact(0, 0, 2'b10, 0, 32'h02, 0);
    `CHK("ldw02_mis", mis, 1'b1)
    `CHK("ldw02_data", rd, 32'h0)
    `CHK("ldw02_lat", lat, 1)
    xact(0, 1, 2'b01, 0, 32'h05, 32'hFFFF_FFFF);
    `CHK("sth05_mis", mis, 1'b1)
    `CHK("sth05_data", rd, 32'h0)
    `CHK("sth05_lat", lat, 1)
    xact(0, 0, 2'b10, 0, 32'h04, 0);
    `CHK("ld04_word", rd, 32'h0000_0001)
    `CHK("ld04_mis", mis, 1'b0)

    // Wrap and zero wait states
    xact(2, 1, 2'b10, 0, 32'h400, 32'h1234_5678);
    `CHK("st400_lat", lat, 1)
    xact(2, 0, 2'b10, 0, 32'h000, 0);
    `CHK("ld000_wrap", rd, 32'h1234_5678)
    `CHK("ld000_lat", lat, 1)

    // Back-to-back with req_valid held high: one accept every 2 cycles
    @(negedge clk);
    drive(2, 1, 0, 2'b10, 0, 32'h0, 0);
    got = 0; bad = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (rv(2)) begin
        got++;
        if (rdat(2) !== 32'h1234_5678) bad++;
      end
    end
    drive(2, 0, 0, 2'b10, 0, 0, 0);
    `CHK("b2b_count", got, 4)
    `CHK("b2b_data_errs", bad, 0)

    // Reset during WAIT aborts a store (3 wait states)
    @(negedge clk);
    drive(1, 1, 1, 2'b10, 0, 32'h08, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 drive(1, 0, 0, 2'b10, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    got = 0;
    for (int k = 0; k < 2; k++) begin @(negedge clk); if (rv(1)) got++; end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); if (rv(1)) got++; end
    `CHK("rst_abort_resp", got, 0)
    `CHK("rst_abort_ready", rdy(1), 1'b1)
    xact(1, 0, 2'b10, 0, 32'h08, 0);
    `CHK("ld08_after_abort", rd, 32'h0000_0002)
    `CHK("ld08_lat", lat, 4)

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_hs_ctrl.md
Name: dmem_hs_ctrl

Overview:
- Parametrised synchronous data memory for the MIPS32 pipeline MEM stage. Successor to the flat word-addressed RAM.
- Adds configurable depth and byte addressing, byte/half/word accesses with sign or zero extension, and misalignment detection.
- Adds a valid/ready request handshake with programmable wait states, so the pipeline can stall on slow memory.

Parameters:
- ADDR_WIDTH, 10: byte-address bits decoded. Depth = 2^(ADDR_WIDTH-2) 32-bit words. Legal range 3..16.
- WAIT_CYCLES, 1: wait states between acceptance and access. 0 is legal.
- INIT_INDEX, 1: 1 means word i is initialised to i at time zero; 0 means all words are initialised to zero.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- address  in  32  byte address. Bits above ADDR_WIDTH-1 are ignored.
- write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response strobe.
- read_data  out  32  extended load result; 0 for stores and misaligned requests.
- misaligned  out  1  qualifies resp_valid; 1 means the access was rejected.

Behaviour:
- Reset (asynchronous): state=IDLE, req_ready=1, resp_valid=0, read_data=0, misaligned=0, wait counter=0.
  - Memory contents are not affected by reset.
  - Reset mid-transaction aborts the transaction. A pending store is never committed and no response is issued.
- FSM states: IDLE, WAIT, RESP.
  - req_ready=1 only in IDLE.
- Acceptance: req_valid && req_ready at a rising edge.
  - All request fields are latched at that edge. Inputs are don't-care afterwards.
- IDLE transitions on acceptance:
  - Misaligned request: go to RESP with misaligned=1, read_data=0. No wait states apply.
  - Aligned request with WAIT_CYCLES>0: go to WAIT, counter=WAIT_CYCLES-1.
  - Aligned request with WAIT_CYCLES=0: go to RESP directly, and the access is performed at that same edge.
- WAIT: counter decrements each cycle.
  - At the edge where counter==0, go to RESP and perform the access.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
  - read_data and misaligned hold their values until the next response.
- Latency: resp_valid is asserted in cycle N+WAIT_CYCLES+1, where acceptance occurs at edge N.
  - Max throughput is one request per WAIT_CYCLES+2 cycles.
  - A request arriving while busy is held off by req_ready=0.
- Alignment rules:
  - half: address[0] must be 0.
  - word: address[1:0] must be 00.
  - byte: always aligned.
  - A misaligned store writes nothing.
- Byte lanes are little-endian: offset 0 maps to bits [7:0], offset 3 to bits [31:24].
- Word index = address[ADDR_WIDTH-1:2]. Higher addresses wrap (alias) onto this range.
- Store access: only the selected lanes are written; other bytes are preserved.
  - Byte store uses write_data[7:0]. Half store uses write_data[15:0].
- Load access:
  - The selected byte/half is right-aligned into read_data.
  - It is then extended to 32 bits per req_unsigned (sign-extended when 0, zero-extended when 1).
  - Word loads ignore req_unsigned.
- Stores respond with read_data=0, misaligned=0.
- A load following a store to the same location returns the stored value, since the transactions are strictly sequential.

Test Plan:
- Defaults. After reset, load word at 0x14 → response in cycle N+2 with read_data=0x00000005. req_ready is 0 during WAIT and RESP.
- Byte-store merge. Store byte 0xAB at 0x11, then load word at 0x10 → 0x0000AB04. Load byte at 0x11 with signed extension → 0xFFFFFFAB; with unsigned extension → 0x000000AB.
- Half-store merge and sign extension. Store half 0x8001 at 0x22, then load word at 0x20 → 0x80010008. Load half at 0x22 with signed extension → 0xFFFF8001.
- Misalignment. Load word at 0x02 and store half at 0x05 → each gives a one-cycle response with misaligned=1 and read_data=0, one cycle after acceptance. A subsequent load word at 0x04 → 0x00000001, showing memory is unchanged.
- Reset mid-store (WAIT_CYCLES=3). Store word 0xDEADBEEF at 0x08 and assert rst during WAIT → no resp_valid. After release, load word at 0x08 → 0x00000002.
- Wrap and zero-wait (ADDR_WIDTH=10, WAIT_CYCLES=0). Store word 0x12345678 at 0x400, then load word at 0x000 → 0x12345678. Response arrives one cycle after acceptance. Back-to-back requests with req_valid held high are accepted every 2 cycles.
